// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the FizzBuzz ASCII stream generator.
package fizzbuzz_pkg;

    // Largest BCD width supported by the MAX_COUNT conversion helper
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // "Fizz" and "Buzz", first character at index 0
    localparam logic [7:0] FIZZ_TBL [4] = '{8'h46, 8'h69, 8'h7A, 8'h7A};
    localparam logic [7:0] BUZZ_TBL [4] = '{8'h42, 8'h75, 8'h7A, 8'h7A};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_WORD,
        ST_DIGITS,
        ST_CR,
        ST_LF,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Per-byte handshake with the transmitter
    typedef enum logic [1:0] {
        HS_IDLE,
        HS_WAIT_HI,
        HS_WAIT_LO
    } hs_t;

    // Binary to packed BCD (digit 0 in bits [3:0]), used for constant compares
    function automatic logic [MAX_DIGITS*4-1:0] to_bcd(input int unsigned value);
        logic [MAX_DIGITS*4-1:0] bcd;
        int unsigned             rem;
        bcd = '0;
        rem = value;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            bcd[i*4 +: 4] = 4'(rem % 10);
            rem           = rem / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter starting at 1, with leading-digit index output.
module bcd_counter #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [DIGITS*4-1:0]   o_digits,
    output logic [7:0]            o_lead
);

    // The sequence always starts at 1, so clear loads 1 rather than 0
    localparam logic [DIGITS*4-1:0] CNT_ONE = {{(DIGITS*4-1){1'b0}}, 1'b1};

    logic [DIGITS*4-1:0] cnt_q;
    logic [DIGITS*4-1:0] cnt_d;
    logic                carry;

    // Ripple-carry decimal increment; clear takes priority
    always_comb begin
        cnt_d = cnt_q;
        carry = i_inc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[i*4 +: 4] == 4'd9) begin
                    cnt_d[i*4 +: 4] = 4'd0;
                end else begin
                    cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
        if (i_clr) begin
            cnt_d = CNT_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ONE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Index of the most significant non-zero digit (0 when the value is below 10)
    always_comb begin
        o_lead = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt_q[i*4 +: 4] != 4'd0) begin
                o_lead = 8'(i);
            end
        end
    end

    assign o_digits = cnt_q;

endmodule

// File: rtl/fizzbuzz_gen.sv
// FizzBuzz 1..MAX_COUNT as CR/LF-terminated ASCII lines, paced by a UART busy flag.
module fizzbuzz_gen #(
    parameter int unsigned MAX_COUNT = 100,
    parameter int unsigned DIGITS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_busy,
    output logic       o_done
);

    import fizzbuzz_pkg::*;

    if (DIGITS == 0 || DIGITS > MAX_DIGITS || MAX_COUNT == 0 || MAX_COUNT >= 10**DIGITS) begin : g_param_check
        $error("fizzbuzz_gen: MAX_COUNT must be in 1 .. 10**DIGITS-1 and DIGITS in 1 .. %0d", MAX_DIGITS);
    end

    localparam logic [MAX_DIGITS*4-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    state_t               state_q, state_d;
    hs_t                  hs_q, hs_d;
    logic [7:0]           idx_q, idx_d;
    logic [1:0]           mod3_q, mod3_d;
    logic [2:0]           mod5_q, mod5_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 bcd_clr;
    logic                 bcd_inc;
    logic [DIGITS*4-1:0]  digits;
    logic [7:0]           lead;
    logic                 issue;
    logic                 can_send;
    logic                 byte_done;
    logic                 is_fizz;
    logic                 is_buzz;
    logic                 is_last;
    logic [3:0]           cur_digit;
    logic [7:0]           word_char;
    logic [7:0]           word_last;

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (bcd_clr),
        .i_inc    (bcd_inc),
        .o_digits (digits),
        .o_lead   (lead)
    );

    assign is_fizz   = (mod3_q == 2'd0);
    assign is_buzz   = (mod5_q == 3'd0);
    assign is_last   = (digits == MAX_BCD[DIGITS*4-1:0]);
    assign can_send  = (hs_q == HS_IDLE) && !i_tx_busy;
    assign byte_done = (hs_q == HS_WAIT_LO) && !i_tx_busy;

    // Character selection: current BCD digit and current word character
    always_comb begin
        cur_digit = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == 8'(i)) begin
                cur_digit = digits[i*4 +: 4];
            end
        end
        // FizzBuzz is indices 0..3 from the Fizz table then 4..7 from the Buzz table
        if (is_fizz && !(is_buzz && idx_q[2])) begin
            word_char = FIZZ_TBL[idx_q[1:0]];
        end else begin
            word_char = BUZZ_TBL[idx_q[1:0]];
        end
        word_last = (is_fizz && is_buzz) ? 8'd7 : 8'd3;
    end

    // Main sequencer: next state, byte issue and counters
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mod3_d     = mod3_q;
        mod5_d     = mod5_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_clr    = 1'b0;
        bcd_inc    = 1'b0;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_EVAL;
                    busy_d  = 1'b1;
                    bcd_clr = 1'b1;
                    mod3_d  = 2'd1;
                    mod5_d  = 3'd1;
                end
            end
            ST_EVAL: begin
                if (is_fizz || is_buzz) begin
                    state_d = ST_WORD;
                    idx_d   = '0;
                end else begin
                    state_d = ST_DIGITS;
                    idx_d   = lead;
                end
            end
            ST_WORD: begin
                if (can_send) begin
                    issue      = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = word_char;
                    if (idx_q == word_last) begin
                        state_d = ST_CR;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            ST_DIGITS: begin
                if (can_send) begin
                    issue      = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ASCII_ZERO + {4'h0, cur_digit};
                    if (idx_q == 8'd0) begin
                        state_d = ST_CR;
                    end else begin
                        idx_d = idx_q - 8'd1;
                    end
                end
            end
            ST_CR: begin
                if (can_send) begin
                    issue      = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ASCII_CR;
                    state_d    = ST_LF;
                    idx_d      = '0;
                end
            end
            ST_LF: begin
                // idx marks whether LF has been issued; stay until it completes
                if (idx_q == 8'd0) begin
                    if (can_send) begin
                        issue      = 1'b1;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ASCII_LF;
                        idx_d      = 8'd1;
                    end
                end else if (byte_done) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                bcd_inc = 1'b1;
                mod3_d  = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
                mod5_d  = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;
                state_d = ST_EVAL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte handshake: after a strobe wait for busy to rise, then to fall
    always_comb begin
        hs_d = hs_q;
        case (hs_q)
            HS_IDLE:    if (issue)      hs_d = HS_WAIT_HI;
            HS_WAIT_HI: if (i_tx_busy)  hs_d = HS_WAIT_LO;
            HS_WAIT_LO: if (!i_tx_busy) hs_d = HS_IDLE;
            default:                    hs_d = HS_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hs_q       <= HS_IDLE;
            idx_q      <= '0;
            mod3_q     <= 2'd1;
            mod5_q     <= 3'd1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hs_d;
            idx_q      <= idx_d;
            mod3_q     <= mod3_d;
            mod5_q     <= mod5_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_fizzbuzz_gen.sv
// Scoreboard bench for fizzbuzz_gen: MAX_COUNT=15 and MAX_COUNT=100 instances with UART busy models.
module tb_fizzbuzz_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, busy_a, valid_a, obusy_a, done_a;
    logic [7:0] data_a;
    logic       rst_b, start_b, busy_b, valid_b, obusy_b, done_b;
    logic [7:0] data_b;

    int         len_a = 20;
    int         ucnt_a = 0;
    int         ucnt_b = 0;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] exp_a, exp_b;
    int         strobes_a = 0, strobes_b = 0;
    int         dones_a = 0, dones_b = 0;
    int         lines_b = 0, special_b = 0;
    logic [63:0] line_b = '0;
    logic       busy_prev_a = 1'b0, busy_prev_b = 1'b0;
    int         nb;

    fizzbuzz_gen #(.MAX_COUNT(15), .DIGITS(2)) dut_a (
        .clk(clk), .rst(rst_a), .i_start(start_a), .i_tx_busy(busy_a),
        .o_tx_data(data_a), .o_tx_valid(valid_a), .o_busy(obusy_a), .o_done(done_a)
    );

    fizzbuzz_gen #(.MAX_COUNT(100), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst_b), .i_start(start_b), .i_tx_busy(busy_b),
        .o_tx_data(data_b), .o_tx_valid(valid_b), .o_busy(obusy_b), .o_done(done_b)
    );

    // UART transmitter models: busy for len cycles starting the cycle after a strobe
    always @(posedge clk) begin
        if (valid_a && ucnt_a == 0) ucnt_a <= len_a;
        else if (ucnt_a != 0)       ucnt_a <= ucnt_a - 1;
        if (valid_b && ucnt_b == 0) ucnt_b <= 20;
        else if (ucnt_b != 0)       ucnt_b <= ucnt_b - 1;
    end
    assign busy_a = (ucnt_a != 0);
    assign busy_b = (ucnt_b != 0);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string line_body(input int n);
        if (n % 15 == 0) return "FizzBuzz";
        if (n % 3 == 0)  return "Fizz";
        if (n % 5 == 0)  return "Buzz";
        return $sformatf("%0d", n);
    endfunction

    task automatic push_expected(input bit to_b, input int max_n, output int n_bytes);
        string      s;
        logic [7:0] ch;
        n_bytes = 0;
        for (int n = 1; n <= max_n; n++) begin
            s = {line_body(n), "\r\n"};
            for (int i = 0; i < s.len(); i++) begin
                ch = s[i];
                if (to_b) q_b.push_back(ch);
                else      q_a.push_back(ch);
                n_bytes++;
            end
        end
    endtask

    task automatic pulse_start(input bit to_b);
        @(negedge clk);
        if (to_b) start_b = 1'b1;
        else      start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit to_b, input int bound);
        int k = 0;
        while (k < bound && !(to_b ? done_b : done_a)) begin
            @(negedge clk);
            k++;
        end
        check_eq(to_b ? "b_done_seen" : "a_done_seen", {63'd0, to_b ? done_b : done_a}, 64'd1);
    endtask

    // Monitor A: busy discipline and byte scoreboard
    always @(negedge clk) begin
        if (valid_a) begin
            strobes_a++;
            check_eq("a_busy_near_strobe", {62'd0, busy_a, busy_prev_a}, 64'd0);
            check_eq("a_strobe_expected", {63'd0, q_a.size() != 0}, 64'd1);
            if (q_a.size() != 0) begin
                exp_a = q_a.pop_front();
                check_eq("a_byte", {56'd0, data_a}, {56'd0, exp_a});
            end
        end
        if (done_a) dones_a++;
        busy_prev_a = busy_a;
    end

    // Monitor B: scoreboard plus content of selected lines
    always @(negedge clk) begin
        if (valid_b) begin
            strobes_b++;
            check_eq("b_busy_near_strobe", {62'd0, busy_b, busy_prev_b}, 64'd0);
            check_eq("b_strobe_expected", {63'd0, q_b.size() != 0}, 64'd1);
            if (q_b.size() != 0) begin
                exp_b = q_b.pop_front();
                check_eq("b_byte", {56'd0, data_b}, {56'd0, exp_b});
            end
            if (data_b == 8'h0A) begin
                lines_b++;
                case (lines_b)
                    7:   begin check_eq("b_line7",   line_b, 64'h37);         special_b++; end // "7"
                    10:  begin check_eq("b_line10",  line_b, 64'h42757A7A);   special_b++; end // "Buzz"
                    97:  begin check_eq("b_line97",  line_b, 64'h3937);       special_b++; end // "97"
                    99:  begin check_eq("b_line99",  line_b, 64'h46697A7A);   special_b++; end // "Fizz"
                    100: begin check_eq("b_line100", line_b, 64'h42757A7A);   special_b++; end // "Buzz"
                    default: ;
                endcase
                line_b = '0;
            end else if (data_b != 8'h0D) begin
                line_b = {line_b[55:0], data_b};
            end
        end
        if (done_b) dones_b++;
        busy_prev_b = busy_b;
    end

    initial begin
        int k;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("a_rst_valid", {63'd0, valid_a}, 64'd0);
        check_eq("a_rst_data",  {56'd0, data_a},  64'd0);
        check_eq("a_rst_busy",  {63'd0, obusy_a}, 64'd0);
        check_eq("a_rst_done",  {63'd0, done_a},  64'd0);
        check_eq("b_rst_valid", {63'd0, valid_b}, 64'd0);
        check_eq("b_rst_busy",  {63'd0, obusy_b}, 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Full 1..15 sequence, start latency, starts ignored mid-run and in the done cycle
        strobes_a = 0; dones_a = 0;
        push_expected(1'b0, 15, nb);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("a_busy_after_start", {63'd0, obusy_a}, 64'd1);
        @(negedge clk);
        check_eq("a_no_strobe_at_1", {63'd0, valid_a}, 64'd0);
        @(negedge clk);
        check_eq("a_first_strobe_at_2", {63'd0, valid_a}, 64'd1);
        repeat (250) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 20000);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("a_done_one_cycle", {63'd0, done_a}, 64'd0);
        repeat (100) @(negedge clk);
        check_eq("a_strobe_count", strobes_a, 64'd73);
        check_eq("a_done_count", dones_a, 64'd1);
        check_eq("a_queue_drained", q_a.size(), 64'd0);
        check_eq("a_idle_busy", {63'd0, obusy_a}, 64'd0);

        // Slow transmitter: busy 50 cycles per byte
        len_a = 50;
        strobes_a = 0; dones_a = 0;
        push_expected(1'b0, 15, nb);
        pulse_start(1'b0);
        wait_done(1'b0, 20000);
        repeat (60) @(negedge clk);
        check_eq("a_slow_strobe_count", strobes_a, 64'd73);
        check_eq("a_slow_done_count", dones_a, 64'd1);
        check_eq("a_slow_queue_drained", q_a.size(), 64'd0);

        // Reset during line 4, then restart from "1"
        len_a = 20;
        strobes_a = 0; dones_a = 0;
        push_expected(1'b0, 15, nb);
        pulse_start(1'b0);
        k = 0;
        while (strobes_a < 13 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq("a_reached_line4", {63'd0, strobes_a >= 13}, 64'd1);
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("a_midrst_valid", {63'd0, valid_a}, 64'd0);
        check_eq("a_midrst_busy",  {63'd0, obusy_a}, 64'd0);
        rst_a = 1'b0;
        q_a.delete();
        strobes_a = 0; dones_a = 0;
        push_expected(1'b0, 15, nb);
        pulse_start(1'b0);
        wait_done(1'b0, 20000);
        repeat (30) @(negedge clk);
        check_eq("a_restart_strobe_count", strobes_a, 64'd73);
        check_eq("a_restart_done_count", dones_a, 64'd1);
        check_eq("a_restart_queue_drained", q_a.size(), 64'd0);

        // MAX_COUNT=100 full run
        strobes_b = 0; dones_b = 0;
        push_expected(1'b1, 100, nb);
        pulse_start(1'b1);
        wait_done(1'b1, 60000);
        repeat (30) @(negedge clk);
        check_eq("b_strobe_count", strobes_b, nb);
        check_eq("b_special_lines", special_b, 64'd5);
        check_eq("b_done_count", dones_b, 64'd1);
        check_eq("b_queue_drained", q_b.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fizzbuzz_gen.md
FIZZBUZZ_GEN -- requirements
Module: fizzbuzz_gen

Interface
REQ-001 The block SHALL have parameter MAX_COUNT, default 100, giving the last number of the sequence (1..MAX_COUNT).
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of BCD digits; the requirement MAX_COUNT < 10**DIGITS SHALL be checked at elaboration.
REQ-003 The block SHALL have port clk, input, 1 bit: clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port i_start, input, 1 bit: single-cycle request to emit the full sequence.
REQ-006 The block SHALL have port i_tx_busy, input, 1 bit: busy flag from the downstream 8n1 UART transmitter.
REQ-007 The block SHALL have port o_tx_data, output, 8 bits: ASCII byte to the transmitter.
REQ-008 The block SHALL have port o_tx_valid, output, 1 bit: one-cycle byte strobe.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high from the cycle after i_start is accepted until o_done.
REQ-010 The block SHALL have port o_done, output, 1 bit: one-cycle pulse after the last byte completes.

Function
REQ-011 For each n = 1..MAX_COUNT in order, the block SHALL emit the line body followed by 0x0D 0x0A.
- Body is "FizzBuzz" if n mod 15 = 0, else "Fizz" if n mod 3 = 0, else "Buzz" if n mod 5 = 0.
- Otherwise the body is the decimal digits of n, MSB first, with leading zeros suppressed.
REQ-012 Divisibility SHALL come from a mod-3 counter (0..2) and a mod-5 counter (0..4), both initialised to 1 with n = 1 and wrapping to 0; no dividers.
REQ-013 n SHALL be held in a DIGITS-digit BCD counter that increments once per line.
REQ-014 FSM states SHALL be:
- IDLE -> EVAL on i_start.
- EVAL -> WORD or DIGITS.
- WORD/DIGITS -> CR -> LF.
- LF -> NEXT, or DONE when n = MAX_COUNT.
- NEXT -> EVAL.
- DONE -> IDLE.
REQ-015 o_tx_valid SHALL be high for exactly one cycle per byte, with o_tx_data valid in that cycle and held until the next strobe.
REQ-016 A byte SHALL be issued only when i_tx_busy = 0 and the previous byte is complete, meaning i_tx_busy was sampled high and then low after its strobe.
REQ-017 The first o_tx_valid SHALL occur 2 cycles after i_start is sampled in IDLE, provided i_tx_busy = 0.
REQ-018 i_start SHALL be ignored in every state other than IDLE, including the o_done cycle.
REQ-019 o_done SHALL pulse in the DONE cycle, which immediately follows the cycle in which i_tx_busy falls after the final 0x0A.
REQ-020 The n = MAX_COUNT boundary SHALL be detected by BCD compare; the BCD counter SHALL NOT wrap past MAX_COUNT.

Reset
REQ-021 On rst, regardless of state, the block SHALL set state = IDLE, o_tx_valid = 0, o_tx_data = 0x00, o_busy = 0, o_done = 0, n = 1, mod3 = 1, mod5 = 1 and clear the handshake flags, all effective the next cycle.
REQ-022 Reset mid-line SHALL discard the partial line; the next i_start SHALL restart the sequence from "1".

Structure
REQ-023 Package fizzbuzz_pkg SHALL hold the FSM state enum, the ASCII constants (CR, LF, '0'), and the "Fizz"/"Buzz" character tables.
REQ-024 Sub-module bcd_counter SHALL provide the DIGITS-digit BCD incrementer with synchronous clear, increment enable, digit outputs and a leading-digit index.
REQ-025 The byte handshake SHALL be a small sub-FSM inside fizzbuzz_gen, not a separate module.

Verification
REQ-026 MAX_COUNT=15, driven by a UART transmitter model (2 clk/bit) -> stream "1\r\n2\r\nFizz\r\n4\r\nBuzz\r\n...14\r\nFizzBuzz\r\n", exactly 73 strobes, one o_done.
REQ-027 MAX_COUNT=100 -> line 7 is "7" (not "007"), line 10 "Buzz", line 99 "Fizz", line 100 "Buzz", and line 97 "97".
REQ-028 i_tx_busy held high 50 cycles after each strobe -> no strobe while busy, next strobe no earlier than 1 cycle after busy falls, and byte order unchanged.
REQ-029 rst asserted during line 4 -> o_tx_valid = 0 and o_busy = 0 next cycle; after re-start the first bytes are "1\r\n".
REQ-030 i_start pulsed mid-sequence and in the o_done cycle -> ignored, no second sequence; a later i_start in IDLE -> full sequence again.
